// File: rtl/row_transform_pipe.sv
// Two-stage streaming 4-point DST-VII / DCT-II row transform with valid/ready flow control.
// Optional output saturation is enabled by defining ROW_TRANSFORM_SAT_EN.
module row_transform_pipe #(
  parameter int unsigned IN_W    = 12,
  parameter int unsigned COEFF_W = 8,
  parameter int unsigned OUT_W   = IN_W + COEFF_W + 2,
  parameter int unsigned SHIFT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [4*IN_W-1:0]    s_row,
  input  logic                 s_mode,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [4*OUT_W-1:0]   m_row,
  output logic                 m_mode,
  output logic                 m_last
);

  localparam int unsigned PW      = IN_W + COEFF_W;
  localparam int unsigned ACC_W   = IN_W + COEFF_W + 2;
  localparam int unsigned RW      = ACC_W + 1;
  localparam int unsigned BIAS_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND_BIAS = (SHIFT > 0) ? (RW'(1) <<< BIAS_SH) : RW'(0);

  // Kernel table indexed by {mode, k, j}: entries 0..15 DST-VII, 16..31 DCT-II.
  localparam logic signed [7:0] KTAB [32] = '{
    8'sd29,  8'sd55,  8'sd74,  8'sd84,
    8'sd74,  8'sd74,  8'sd0,  -8'sd74,
    8'sd84, -8'sd29, -8'sd74,  8'sd55,
    8'sd55, -8'sd84,  8'sd74, -8'sd29,
    8'sd64,  8'sd64,  8'sd64,  8'sd64,
    8'sd83,  8'sd36, -8'sd36, -8'sd83,
    8'sd64, -8'sd64, -8'sd64,  8'sd64,
    8'sd36, -8'sd83,  8'sd83, -8'sd36
  };

  logic                 advance;
  logic                 in_hs;
  logic [1:0]           row_cnt;
  logic                 blk_mode;
  logic                 row_mode_c;

  logic signed [PW-1:0] prod_c  [4][4];
  logic signed [PW-1:0] s1_prod [4][4];
  logic                 s1_valid;
  logic [1:0]           s1_idx;
  logic                 s1_mode;

  logic signed [ACC_W-1:0] acc_c [4];
  logic signed [RW-1:0]    rnd_c [4];
  logic [4*OUT_W-1:0]      res_c;

  // Stall-all flow control: every stage moves only when the output slot frees up.
  assign advance = !m_valid || m_ready;
  assign s_ready = advance;
  assign in_hs   = s_valid && advance;

  // Row 0 takes the live mode; later rows reuse the block's latched mode.
  assign row_mode_c = (row_cnt == 2'd0) ? s_mode : blk_mode;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        prod_c[k][j] = PW'($signed(s_row[j*IN_W +: IN_W]))
                     * PW'(KTAB[{row_mode_c, 2'(k), 2'(j)}]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      acc_c[k] = ACC_W'(s1_prod[k][0]) + ACC_W'(s1_prod[k][1])
               + ACC_W'(s1_prod[k][2]) + ACC_W'(s1_prod[k][3]);
      rnd_c[k] = (RW'(acc_c[k]) + RND_BIAS) >>> SHIFT;
    end
  end

`ifdef ROW_TRANSFORM_SAT_EN
  generate
    if (OUT_W < RW) begin : g_sat
      localparam logic signed [RW-1:0] SAT_MAX = RW'({1'b0, {(OUT_W-1){1'b1}}});
      localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
      always_comb begin
        res_c = '0;
        for (int k = 0; k < 4; k++) begin
          if (rnd_c[k] > SAT_MAX)      res_c[k*OUT_W +: OUT_W] = OUT_W'(SAT_MAX);
          else if (rnd_c[k] < SAT_MIN) res_c[k*OUT_W +: OUT_W] = OUT_W'(SAT_MIN);
          else                         res_c[k*OUT_W +: OUT_W] = OUT_W'(rnd_c[k]);
        end
      end
    end else begin : g_wide
      always_comb begin
        res_c = '0;
        for (int k = 0; k < 4; k++) res_c[k*OUT_W +: OUT_W] = OUT_W'(rnd_c[k]);
      end
    end
  endgenerate
`else
  // Wrap by keeping the low OUT_W bits (sign-extends when OUT_W is wider).
  always_comb begin
    res_c = '0;
    for (int k = 0; k < 4; k++) res_c[k*OUT_W +: OUT_W] = OUT_W'(rnd_c[k]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt  <= '0;
      blk_mode <= 1'b0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_mode  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) s1_prod[k][j] <= '0;
      end
      m_valid  <= 1'b0;
      m_row    <= '0;
      m_mode   <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      if (in_hs) begin
        row_cnt <= row_cnt + 2'd1;
        if (row_cnt == 2'd0) blk_mode <= s_mode;
      end
      if (advance) begin
        s1_valid <= s_valid;
        if (s_valid) begin
          s1_prod <= prod_c;
          s1_idx  <= row_cnt;
          s1_mode <= row_mode_c;
        end
        m_valid <= s1_valid;
        if (s1_valid) begin
          m_row  <= res_c;
          m_mode <= s1_mode;
          m_last <= (s1_idx == 2'd3);
        end
      end
    end
  end

endmodule

// File: tb/tb_row_transform_pipe.sv
// Directed, table-driven bench for row_transform_pipe with backpressure, extremes and reset cases.
module tb_row_transform_pipe;

  localparam int IN_W  = 12;
  localparam int OUT_W = 22;

  typedef struct packed {
    logic [4*IN_W-1:0] row;
    logic              mode;
    logic              last;
    logic [3:0][31:0]  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst, s_valid, s_mode, m_ready;
  logic [4*IN_W-1:0] s_row;

  logic s_ready, m_valid, m_mode, m_last;
  logic [4*OUT_W-1:0] m_row;
  logic s_ready_a, m_valid_a, m_mode_a, m_last_a;
  logic [63:0] m_row_a;
  logic s_ready_b, m_valid_b, m_mode_b, m_last_b;
  logic [63:0] m_row_b;

  int n_checks = 0;
  int n_pass   = 0;

  int kt [2][4][4] = '{
    '{'{29, 55, 74, 84}, '{74, 74, 0, -74}, '{84, -29, -74, 55}, '{55, -84, 74, -29}},
    '{'{64, 64, 64, 64}, '{83, 36, -36, -83}, '{64, -64, -64, 64}, '{36, -83, 83, -36}}
  };

  always #5 clk = ~clk;

  row_transform_pipe dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_row(s_row),
    .s_mode(s_mode), .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row),
    .m_mode(m_mode), .m_last(m_last));

  row_transform_pipe #(.OUT_W(16), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_row(s_row),
    .s_mode(s_mode), .m_valid(m_valid_a), .m_ready(m_ready), .m_row(m_row_a),
    .m_mode(m_mode_a), .m_last(m_last_a));

  row_transform_pipe #(.OUT_W(16), .SHIFT(7)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_row(s_row),
    .s_mode(s_mode), .m_valid(m_valid_b), .m_ready(m_ready), .m_row(m_row_b),
    .m_mode(m_mode_b), .m_last(m_last_b));

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint field(input logic [4*OUT_W-1:0] v, input int k);
    return longint'($signed(v[k*OUT_W +: OUT_W]));
  endfunction

  function automatic longint field16(input logic [63:0] v, input int k);
    return longint'($signed(v[k*16 +: 16]));
  endfunction

  function automatic logic [4*IN_W-1:0] pk(input int a, input int b, input int c, input int d);
    return {12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic vec_t mkv(input int a, input int b, input int c, input int d, input bit mode,
                               input int e0, input int e1, input int e2, input int e3,
                               input bit last);
    vec_t v;
    v.row  = pk(a, b, c, d);
    v.mode = mode;
    v.last = last;
    v.e    = {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
    return v;
  endfunction

  function automatic longint model(input logic [4*IN_W-1:0] row, input bit mode, input int k);
    longint s = 0;
    for (int j = 0; j < 4; j++) s += longint'($signed(row[j*IN_W +: IN_W])) * kt[mode][k][j];
    return s;
  endfunction

  // One row in, wait (bounded) for its result, then compare latency and contents.
  task automatic send_check(input vec_t v, input logic smode, input string name);
    int lat;
    bit got;
    @(negedge clk);
    s_row = v.row; s_mode = smode; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1; got = 1'b0;
    while (!got && lat <= 6) begin
      if (m_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({name, " latency"}, lat, 2);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s out%0d", name, k), field(m_row, k), longint'($signed(v.e[k])));
    check({name, " m_mode"}, m_mode, v.mode);
    check({name, " m_last"}, m_last, v.last);
  endtask

  task automatic push(input logic [4*IN_W-1:0] row, input logic mode);
    @(negedge clk);
    s_row = row; s_mode = mode; s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  vec_t vt [8];
  vec_t zv;
  logic [4*IN_W-1:0] bp_row [8];
  logic [4*OUT_W-1:0] snap_row;
  logic snap_last;
  int sent, rcvd, cyc;
  bit stalled;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_mode = 1'b0; m_ready = 1'b1; s_row = '0;

    vt[0] = mkv(100, 200, 300, 400, 0, 69700, -7400, 2400, -700, 0);
    vt[1] = mkv(-1, -1, -1, -1, 0, -242, -74, -36, -16, 0);
    vt[2] = mkv(0, 0, 0, 1, 0, 84, -74, 55, -29, 0);
    vt[3] = mkv(2047, 0, 0, -2048, 0, -112669, 303030, 59308, 171977, 1);
    vt[4] = mkv(100, 200, 300, 400, 1, 64000, -28500, 0, -2500, 0);
    vt[5] = mkv(-1, -1, -1, -1, 1, -256, 0, 0, 0, 0);
    vt[6] = mkv(1, 0, 0, 0, 1, 64, 83, 64, 36, 0);
    vt[7] = mkv(2047, 2047, 2047, 2047, 1, 524032, 0, 0, 0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst m_valid", m_valid, 0);
    check("rst m_row0", field(m_row, 0), 0);
    check("rst m_row3", field(m_row, 3), 0);
    check("rst m_mode", m_mode, 0);
    check("rst m_last", m_last, 0);
    check("rst s_ready", s_ready, 1);
    check("rst s_ready_a", s_ready_a, 1);
    check("rst s_ready_b", s_ready_b, 1);
    rst = 1'b0;

    // Zero block, DST
    for (int i = 0; i < 4; i++) begin
      zv = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 3));
      send_check(zv, 1'b0, $sformatf("zero%0d", i));
    end

    // Table vectors: one DST block then one DCT block
    for (int i = 0; i < 8; i++) send_check(vt[i], vt[i].mode, $sformatf("vec%0d", i));

    // Mode latch: s_mode only matters on row 0
    for (int i = 0; i < 4; i++) begin
      zv = mkv(100, 200, 300, 400, 0, 69700, -7400, 2400, -700, (i == 3));
      send_check(zv, (i != 0), $sformatf("latch_dst%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      zv = mkv(100, 200, 300, 400, 1, 64000, -28500, 0, -2500, (i == 3));
      send_check(zv, (i == 0), $sformatf("latch_dct%0d", i));
    end

    // Backpressure streaming against the model
    bp_row[0] = pk(100, 200, 300, 400); bp_row[1] = pk(-1, -1, -1, -1);
    bp_row[2] = pk(0, 0, 0, 1);         bp_row[3] = pk(5, -7, 11, -13);
    for (int i = 4; i < 8; i++) bp_row[i] = bp_row[i-4];
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0;
    while (rcvd < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("bp hold valid", m_valid, 1);
        for (int k = 0; k < 4; k++)
          check($sformatf("bp hold out%0d", k), field(m_row, k), field(snap_row, k));
        check("bp hold last", m_last, snap_last);
      end
      m_ready = (cyc % 3 != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (sent < 8) begin
        s_valid = 1'b1; s_row = bp_row[sent]; s_mode = (sent >= 4);
      end else s_valid = 1'b0;
      #1;
      if (m_valid && m_ready) begin
        for (int k = 0; k < 4; k++)
          check($sformatf("bp row%0d out%0d", rcvd, k), field(m_row, k),
                model(bp_row[rcvd], (rcvd >= 4), k));
        check($sformatf("bp row%0d mode", rcvd), m_mode, (rcvd >= 4));
        check($sformatf("bp row%0d last", rcvd), m_last, (rcvd % 4 == 3));
        rcvd++;
      end
      stalled = m_valid && !m_ready;
      if (stalled) begin
        snap_row = m_row; snap_last = m_last;
      end
      if (s_valid && s_ready) sent++;
    end
    check("bp rows received", rcvd, 8);
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp no extra output", m_valid, 0);
    end

    // Extremes on 16-bit outputs
    push(pk(2047, 2047, 2047, 2047), 1'b0);
    @(negedge clk);
    check("ext a valid", m_valid_a, 1);
`ifdef ROW_TRANSFORM_SAT_EN
    check("ext a out0 sat", field16(m_row_a, 0), 32767);
`else
    check("ext a out0 wrap", field16(m_row_a, 0), -28914);
`endif
    check("ext a mode", m_mode_a, 0);
    check("ext a last", m_last_a, 0);
    push(pk(-2048, -2048, -2048, -2048), 1'b1);
    @(negedge clk);
    check("ext b valid", m_valid_b, 1);
    check("ext b out0 shift7", field16(m_row_b, 0), -3872);
    check("ext b mode", m_mode_b, 0);
    check("ext b last", m_last_b, 0);
    push('0, 1'b0);
    push('0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset mid-block after rows 0..2 are accepted
    @(negedge clk);
    s_valid = 1'b1; s_mode = 1'b0; s_row = pk(1, 2, 3, 4);
    @(negedge clk);
    s_row = pk(5, 6, 7, 8);
    @(negedge clk);
    s_row = pk(9, 10, 11, 12);
    @(negedge clk);
    s_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst m_valid", m_valid, 0);
    check("midrst s_ready", s_ready, 1);
    check("midrst m_last", m_last, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst no stale valid", m_valid, 0);
    end
    for (int i = 0; i < 4; i++) begin
      zv = mkv(1, 0, 0, 0, 1, 64, 83, 64, 36, (i == 3));
      send_check(zv, (i == 0), $sformatf("newblk%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
